// File: rtl/scan_counter.sv
// scan_counter: display-scan ring counter with a built-in prescaler.
// Steps a digit index over N_DIGITS positions (not necessarily a power of
// two) once every PRESCALE enabled clock cycles, in either direction, with
// synchronous load. Drives the index, a one-hot select and step/wrap pulses.
//
// Output handshake: tick is a one-cycle valid strobe with no ready; it is
// high in exactly the first cycle a stepped idx/sel is visible, wrap is only
// meaningful while tick is high, and the consumer must sample in that cycle.
module scan_counter #(
    parameter int N_DIGITS = 4,
    parameter int PRESCALE = 100000,
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1,
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                dir,
    input  logic                load,
    input  logic [IDX_W-1:0]    load_val,
    output logic [IDX_W-1:0]    idx,
    output logic [N_DIGITS-1:0] sel,
    output logic                tick,
    output logic                wrap
);

    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [IDX_W:0]      IDX_LIM  = (IDX_W + 1)'(N_DIGITS);
    localparam logic [N_DIGITS-1:0] SEL_ONE  = {{(N_DIGITS - 1){1'b0}}, 1'b1};

    logic [PRE_W-1:0]    pre_cnt;
    logic                step;
    logic [IDX_W-1:0]    idx_up;
    logic [IDX_W-1:0]    idx_dn;
    logic                wrap_nxt;
    logic [IDX_W-1:0]    load_idx;
    logic [N_DIGITS-1:0] sel_up;
    logic [N_DIGITS-1:0] sel_dn;
    logic [N_DIGITS-1:0] sel_load;

    assign step = en && (pre_cnt == PRE_LAST);

    // Next-index candidates; ring boundaries are explicit so non-power-of-two
    // counts never rely on natural binary wrap-around.
    always_comb begin
        idx_up   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        idx_dn   = (idx == '0) ? IDX_LAST : idx - 1'b1;
        wrap_nxt = dir ? (idx == '0) : (idx == IDX_LAST);
        load_idx = ({1'b0, load_val} < IDX_LIM) ? load_val : '0;
        sel_up   = {sel[N_DIGITS-2:0], sel[N_DIGITS-1]};
        sel_dn   = {sel[0], sel[N_DIGITS-1:1]};
        sel_load = SEL_ONE << load_idx;
    end

    // Prescaler, index, select and pulse registers: rst > load > step > hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
            idx     <= '0;
            sel     <= SEL_ONE;
            tick    <= 1'b0;
            wrap    <= 1'b0;
        end else if (load) begin
            pre_cnt <= '0;
            idx     <= load_idx;
            sel     <= sel_load;
            tick    <= 1'b0;
            wrap    <= 1'b0;
        end else if (step) begin
            pre_cnt <= '0;
            idx     <= dir ? idx_dn : idx_up;
            sel     <= dir ? sel_dn : sel_up;
            tick    <= 1'b1;
            wrap    <= wrap_nxt;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
            if (en) begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/scan_counter.md
# scan_counter

Parametrised display-scan ring counter for the board-level seven-segment display path, replacing the fixed 2-bit free-running counter. It divides the system clock with a built-in prescaler and steps a digit index over a configurable, not necessarily power-of-two, digit count. It supports enable, up/down direction and synchronous load. It drives the digit index, a one-hot select vector, and one-cycle step/wrap pulses to the display mux.

## Interface
- `N_DIGITS`, default 4: number of scanned positions; legal range ≥ 2.
- `PRESCALE`, default 100000: clock cycles per index step; legal range ≥ 1.
- Derived widths:
  - `IDX_W` = max(1, clog2(N_DIGITS)).
  - `PRE_W` = max(1, clog2(PRESCALE)).
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `en`, input, 1: count enable; when low, the prescaler and index hold.
- `dir`, input, 1: 0 = count up, 1 = count down.
- `load`, input, 1: synchronous load strobe.
- `load_val`, input, IDX_W: index value to load.
- `idx`, output, IDX_W: current digit index (registered).
- `sel`, output, N_DIGITS: one-hot select; `sel[idx]`=1 (registered).
- `tick`, output, 1: one-cycle pulse in the first cycle a stepped index is visible.
- `wrap`, output, 1: one-cycle pulse, coincident with `tick`, when the step crossed the ring boundary.

## Operation
- **Internal prescaler:** `pre_cnt`, PRE_W bits, counts 0..PRESCALE-1.
- **Step condition:** `step` = `en` & (`pre_cnt` == PRESCALE-1). With PRESCALE=1, `step` = `en`.
- **Priority, per rising edge:** `rst` > `load` > `step` > hold.
- **Reset:** `pre_cnt`=0, `idx`=0, `sel`=1 (bit 0), `tick`=0, `wrap`=0.
- **Load:**
  - `idx` = `load_val` if `load_val` < N_DIGITS, else 0.
  - `sel` tracks `idx`.
  - `pre_cnt`=0.
  - `tick`=0 and `wrap`=0.
  - Load is honoured regardless of `en`.
- **Step, up (`dir`=0):** `idx` = `idx`+1; from N_DIGITS-1 it goes to 0 and `wrap` is set.
- **Step, down (`dir`=1):** `idx` = `idx`-1; from 0 it goes to N_DIGITS-1 and `wrap` is set.
- **On any step:**
  - `pre_cnt` returns to 0.
  - `tick`=1 for the following cycle.
  - `sel` is rotated in the same direction, never recomputed stale.
- **Enabled, no step:** `pre_cnt` increments; `tick`=`wrap`=0.
- **`en`=0:** `pre_cnt`, `idx` and `sel` hold; `tick`=`wrap`=0.
- **Direction:** `dir` is sampled only at the step edge. Changing it mid-period takes effect at the next step; no pre_cnt reset.
- **Invariants:**
  - `idx` < N_DIGITS at all times.
  - `sel` is exactly one-hot and equals 1<<`idx`.
  - The arithmetic never relies on natural 2^IDX_W wrap-around.

## Timing
- All outputs are registered, with no combinational input-to-output path.
- **Step period:** exactly PRESCALE enabled cycles. Starting from `pre_cnt`=0 with `en` held high, `idx` changes on the PRESCALE-th rising edge.
- **tick/wrap width:** both are high exactly one cycle, aligned with the new `idx`/`sel`.
- **Latency:**
  - `load` to new `idx`: 1 cycle.
  - `rst` to reset values: 1 cycle, on the first edge with `rst`=1.
- **load with step on the same edge:** load wins; no `tick`.
- **rst with load on the same edge:** rst wins.
- **Reset mid-period:** the partial prescale count is discarded, and the next step occurs PRESCALE enabled cycles after `rst` drops.
- **Enable gaps:** deasserting `en` for k cycles delays the step by exactly k cycles. The count is preserved, not restarted.

## Test plan
- **Reset and up-count wrap.** N_DIGITS=5, PRESCALE=3, `en`=1, `dir`=0, hold `rst` for 2 cycles, then release.
  - `idx` sequence 0,1,2,3,4,0, with each value lasting 3 cycles.
  - `sel` = 00001→00010→…→10000→00001.
  - `tick` pulses every 3rd cycle; `wrap` pulses only on 4→0.
- **Down count.** Same configuration with `dir`=1 from reset.
  - `idx` = 0,4,3,2,1,0.
  - `wrap` pulses on 0→4 and at no other step.
- **Enable gap.** PRESCALE=4; drop `en` for 5 cycles when `pre_cnt`=2.
  - The step arrives exactly 5 cycles later than nominal.
  - `idx`, `sel` and `tick`=0 hold during the gap.
- **Load, including out-of-range and collision.**
  - `load_val`=3: next cycle `idx`=3, `sel`=01000, `tick`=0, and the next step follows after a full PRESCALE.
  - `load_val`=6 with N_DIGITS=5: `idx`=0.
  - `load` asserted in a step cycle: no `tick`.
- **PRESCALE=1 and reset priority.**
  - N_DIGITS=4, `en`=1: `idx` advances every cycle and `tick` stays high continuously.
  - Assert `rst` together with `load`=1, `load_val`=2: next cycle `idx`=0, `sel`=0001, `tick`=`wrap`=0.
- **Continuous invariant check.** Across randomised `en`/`dir`/`load` for 10k cycles, `sel` == 1<<`idx` and `idx` < N_DIGITS every cycle.
